// File: rtl/systolic_pkg.sv
// Shared types and index helpers for the systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CLEAR   = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Edges from the start-accepting edge to the edge that raises done
  function automatic int latency(input int k, input int m, input int n);
    return k + m + n;
  endfunction

  function automatic int a_idx(input int i, input int k, input int inner);
    return i * inner + k;
  endfunction

  function automatic int b_idx(input int k, input int j, input int cols);
    return k * cols + j;
  endfunction

  function automatic int c_idx(input int i, input int j, input int cols);
    return i * cols + j;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_mac_pe.sv
// Output-stationary multiply-accumulate cell: forwards a right and b down each cycle.
module mac_pe #(
  parameter int OP_WIDTH  = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [OP_WIDTH-1:0]  a_in,
  input  logic signed [OP_WIDTH-1:0]  b_in,
  output logic signed [OP_WIDTH-1:0]  a_out,
  output logic signed [OP_WIDTH-1:0]  b_out,
  output logic signed [ACC_WIDTH-1:0] acc
);

  logic signed [2*OP_WIDTH-1:0] prod;

  assign prod = a_out * b_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (en) acc <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// Output-stationary systolic C = A x B with start/busy/done handshake and held result.
// Optional macro SYSTOLIC_ACCUMULATE_EN adds an accumulate input that keeps C across runs.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int ROWS      = 2,
  parameter int COLS      = 2,
  parameter int INNER     = 2,
  parameter int OP_WIDTH  = 8,
  parameter int ACC_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
`ifdef SYSTOLIC_ACCUMULATE_EN
  input  logic                              accumulate,
`endif
  input  logic                              start,
  input  logic [ROWS*INNER*OP_WIDTH-1:0]    a_in,
  input  logic [INNER*COLS*OP_WIDTH-1:0]    b_in,
  output logic                              busy,
  output logic                              done,
  output logic                              c_valid,
  output logic [ROWS*COLS*ACC_WIDTH-1:0]    c_out
);

  localparam int LAT = latency(INNER, ROWS, COLS);
  localparam int SW  = $clog2(LAT);

  state_t                           state;
  logic [SW-1:0]                    step;
  logic [ROWS*INNER*OP_WIDTH-1:0]   a_lat;
  logic [INNER*COLS*OP_WIDTH-1:0]   b_lat;
  logic                             pe_clr;
  logic                             pe_en;

  logic signed [OP_WIDTH-1:0]  a_edge [ROWS];
  logic signed [OP_WIDTH-1:0]  b_edge [COLS];
  logic signed [OP_WIDTH-1:0]  a_pass [ROWS][COLS];
  logic signed [OP_WIDTH-1:0]  b_pass [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0] acc_w  [ROWS][COLS];

`ifdef SYSTOLIC_ACCUMULATE_EN
  logic acc_keep;
  assign pe_clr = (state == S_CLEAR) && !acc_keep;
`else
  assign pe_clr = (state == S_CLEAR);
`endif
  assign pe_en = (state == S_COMPUTE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      step     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      c_valid  <= 1'b0;
      a_lat    <= '0;
      b_lat    <= '0;
`ifdef SYSTOLIC_ACCUMULATE_EN
      acc_keep <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            c_valid <= 1'b0;
            a_lat   <= a_in;
            b_lat   <= b_in;
`ifdef SYSTOLIC_ACCUMULATE_EN
            acc_keep <= accumulate;
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          state <= S_COMPUTE;
          step  <= '0;
        end
        S_COMPUTE: begin
          if (step == SW'(LAT - 2)) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            c_valid <= 1'b1;
          end else begin
            step <= step + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Diagonal wavefront: row i / column j lag the step by i / j cycles
  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_edge[i] = '0;
      if (state == S_COMPUTE && int'(step) >= i && int'(step) < i + INNER)
        a_edge[i] = a_lat[OP_WIDTH*a_idx(i, int'(step) - i, INNER) +: OP_WIDTH];
    end
    for (int j = 0; j < COLS; j++) begin
      b_edge[j] = '0;
      if (state == S_COMPUTE && int'(step) >= j && int'(step) < j + INNER)
        b_edge[j] = b_lat[OP_WIDTH*b_idx(int'(step) - j, j, COLS) +: OP_WIDTH];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic signed [OP_WIDTH-1:0] a_src;
      logic signed [OP_WIDTH-1:0] b_src;

      if (j == 0) begin : g_a_edge
        assign a_src = a_edge[i];
      end else begin : g_a_chain
        assign a_src = a_pass[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_src = b_edge[j];
      end else begin : g_b_chain
        assign b_src = b_pass[i-1][j];
      end

      mac_pe #(
        .OP_WIDTH (OP_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .reset(reset),
        .clr  (pe_clr),
        .en   (pe_en),
        .a_in (a_src),
        .b_in (b_src),
        .a_out(a_pass[i][j]),
        .b_out(b_pass[i][j]),
        .acc  (acc_w[i][j])
      );

      assign c_out[ACC_WIDTH*c_idx(i, j, COLS) +: ACC_WIDTH] = acc_w[i][j];
    end
  end

endmodule
